seq_multiplier: RTL and testbench

//   Parametrised iterative shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH product.

---
 rtl/seq_multiplier.sv | 76 +++++++
 tb/tb_seq_multiplier.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: WIDTH x WIDTH -> 2*WIDTH, unsigned or two's complement.
// Works on operand magnitudes, one multiplier bit per cycle, and negates the result at the end.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]         state;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic               neg;

  // Magnitudes stay unsigned, so -2^(WIDTH-1) maps to 2^(WIDTH-1) without overflow.
  always_comb begin
    addend   = {{WIDTH{1'b0}}, mcand} << cnt;
    acc_next = mplier[cnt] ? acc + addend : acc;
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      acc     <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          mcand  <= (is_signed && a[WIDTH-1]) ? -a : a;
          mplier <= (is_signed && b[WIDTH-1]) ? -b : b;
          neg    <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          acc    <= '0;
          cnt    <= '0;
          state  <= CALC;
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          // Negating a zero accumulator yields zero, so no special case is needed.
          if (cnt == CW'(WIDTH-1)) begin
            product <= neg ? -acc_next : acc_next;
            state   <= DONE;
          end
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed WIDTH=8 cases, then random regression on WIDTH=4/8/16
// against an integer-arithmetic reference product.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic iv4, or4, sg4, ir4, ov4;
  logic [3:0] a4, b4;
  logic [7:0] p4;
  logic iv8, or8, sg8, ir8, ov8;
  logic [7:0] a8, b8;
  logic [15:0] p8;
  logic iv16, or16, sg16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  seq_multiplier #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .is_signed(sg4), .out_valid(ov4), .out_ready(or4), .product(p4));
  seq_multiplier #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(sg8), .out_valid(ov8), .out_ready(or8), .product(p8));
  seq_multiplier #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(sg16), .out_valid(ov16), .out_ready(or16), .product(p16));

  int n_cmp = 0;
  int n_err = 0;
  int last_wait;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [15:0] av, input logic [15:0] bv, input logic sg);
    case (w)
      4:       begin iv4 = v;  a4 = av[3:0]; b4 = bv[3:0]; sg4 = sg;  end
      8:       begin iv8 = v;  a8 = av[7:0]; b8 = bv[7:0]; sg8 = sg;  end
      default: begin iv16 = v; a16 = av;     b16 = bv;     sg16 = sg; end
    endcase
  endtask

  task automatic set_or(input int w, input logic r);
    case (w)
      4:       or4 = r;
      8:       or8 = r;
      default: or16 = r;
    endcase
  endtask

  function automatic logic get_ir(input int w);
    case (w)
      4:       return ir4;
      8:       return ir8;
      default: return ir16;
    endcase
  endfunction

  function automatic logic get_ov(input int w);
    case (w)
      4:       return ov4;
      8:       return ov8;
      default: return ov16;
    endcase
  endfunction

  function automatic logic [31:0] get_p(input int w);
    case (w)
      4:       return {24'd0, p4};
      8:       return {16'd0, p8};
      default: return p16;
    endcase
  endfunction

  // Reference: interpret operands as integers, multiply, keep the low 2*w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sg);
    longint m, x, y;
    m = (longint'(1) << w) - 1;
    x = longint'(av) & m;
    y = longint'(bv) & m;
    if (sg && ((x >> (w-1)) & 1) == 1) x = x - (m + 1);
    if (sg && ((y >> (w-1)) & 1) == 1) y = y - (m + 1);
    return 32'((x * y) & ((longint'(1) << (2*w)) - 1));
  endfunction

  function automatic logic [15:0] pick(input int w);
    logic [15:0] m;
    m = 16'((32'd1 << w) - 1);
    case ($urandom_range(0, 5))
      0:       return 16'd0;
      1:       return m;
      2:       return 16'(32'd1 << (w-1));
      default: return 16'($urandom) & m;
    endcase
  endfunction

  // One full transaction; called at a negedge, returns at a negedge with the DUT back in IDLE.
  task automatic op(input int w, input logic [15:0] av, input logic [15:0] bv, input logic sg,
                    input int pre_idle, input int hold, input bit keep_valid,
                    input logic [31:0] exp, input string tag);
    int cyc, lat;
    for (int i = 0; i < pre_idle; i++) begin
      set_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
      set_or(w, 1'($urandom));
      @(negedge clk);
    end
    set_in(w, 1'b1, av, bv, sg);
    cyc = 0;
    while (!get_ir(w) && cyc < 200) begin
      set_or(w, 1'($urandom));
      @(negedge clk);
      cyc++;
    end
    last_wait = cyc;
    chk({tag, " accept"}, get_ir(w), 1'b1);
    @(negedge clk);
    lat = 0;
    while (!get_ov(w) && lat < 4*w + 4) begin
      if (lat == 1) chk({tag, " calc in_ready"}, get_ir(w), 1'b0);
      if (!keep_valid) set_in(w, 1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
      set_or(w, 1'($urandom));
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, w);
    if (!keep_valid) set_in(w, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom));
    chk({tag, " product"}, get_p(w), exp);
    set_or(w, 1'b0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, " hold out_valid"}, get_ov(w), 1'b1);
      chk({tag, " hold in_ready"}, get_ir(w), 1'b0);
      chk({tag, " hold product"}, get_p(w), exp);
    end
    set_or(w, 1'b1);
    @(negedge clk);
    chk({tag, " release out_valid"}, get_ov(w), 1'b0);
    chk({tag, " release in_ready"}, get_ir(w), 1'b1);
    chk({tag, " retained product"}, get_p(w), exp);
    set_or(w, 1'b0);
  endtask

  initial begin
    logic seen;
    logic [15:0] ra, rb;
    logic rs;
    int widths [3] = '{4, 8, 16};

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_in(widths[i], 1'b0, 16'd0, 16'd0, 1'b0);
      set_or(widths[i], 1'b0);
    end
    repeat (2) @(negedge clk);
    chk("reset in_ready", ir8, 1'b1);
    chk("reset out_valid", ov8, 1'b0);
    chk("reset product", p8, 16'h0000);
    chk("reset out_valid w16", ov16, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    op(8, 16'd13,  16'd11,  1'b0, 0, 0, 0, 32'h008F, "u13x11");
    op(8, 16'd255, 16'd255, 1'b0, 1, 0, 0, 32'hFE01, "u255x255");
    op(8, 16'd0,   16'd200, 1'b0, 0, 1, 0, 32'h0000, "u0x200");
    op(8, 16'hFD,  16'd5,   1'b1, 0, 0, 0, 32'hFFF1, "s-3x5");
    op(8, 16'h80,  16'h80,  1'b1, 2, 0, 0, 32'h4000, "s-128x-128");
    op(8, 16'h80,  16'h7F,  1'b1, 0, 0, 0, 32'hC080, "s-128x127");
    op(8, 16'd0,   16'hFF,  1'b1, 0, 0, 0, 32'h0000, "s0x-1");
    op(8, 16'd100, 16'd50,  1'b0, 0, 5, 0, 32'h1388, "backpressure");
    op(8, 16'd7,   16'd9,   1'b0, 0, 0, 0, 32'h003F, "b2b 7x9");

    // Abort an operation partway through CALC with an asynchronous reset.
    set_in(8, 1'b1, 16'd13, 16'd11, 1'b0);
    @(negedge clk);
    set_in(8, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midreset in_ready", ir8, 1'b1);
    chk("midreset out_valid", ov8, 1'b0);
    chk("midreset product", p8, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      seen = seen | ov8;
    end
    chk("aborted op never presented", seen, 1'b0);
    op(8, 16'd2, 16'd3, 1'b0, 0, 0, 0, 32'h0006, "post-reset 2x3");

    // in_valid held through CALC/DONE is taken again at the first IDLE cycle.
    op(8, 16'd2, 16'd3, 1'b1, 0, 2, 1, 32'h0006, "held valid");
    op(8, 16'd2, 16'd3, 1'b1, 0, 0, 0, 32'h0006, "held reaccept");
    chk("held reaccept first idle", last_wait, 0);

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 40; i++) begin
        ra = pick(widths[k]);
        rb = pick(widths[k]);
        rs = 1'($urandom);
        op(widths[k], ra, rb, rs, $urandom_range(0, 2), $urandom_range(0, 3), 0,
           ref_mul(widths[k], ra, rb, rs), $sformatf("rand w%0d %0h*%0h s%0d", widths[k], ra, rb, rs));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
